// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : Decode-to-execute pipeline register with hazard detection.
//             Generates register-file read addresses and a hazard stall.
//             Keeps a saturating count of stall cycles.
//  Config   : ID_FORWARDING_EN defined   -> stall only on EX-stage load-use
//             ID_FORWARDING_EN undefined -> stall on any EX/MEM writeback match
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH     = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_WIDTH-1:0]     pc_in,
  input  logic [WORD_WIDTH-1:0]     instruction_in,
  input  logic                      in_valid,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  input  logic                      use_src1,
  input  logic                      use_src2,
  input  logic [WORD_WIDTH-1:0]     reg1_in,
  input  logic [WORD_WIDTH-1:0]     reg2_in,
  input  logic                      ex_wb_en,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dst,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dst,
  input  logic                      mem_wb_en,
  input  logic                      flush,
  output logic [REG_ADDR_WIDTH-1:0] src1,
  output logic [REG_ADDR_WIDTH-1:0] src2,
  output logic                      hazard_stall,
  output logic                      out_valid,
  output logic [WORD_WIDTH-1:0]     pc_out,
  output logic [WORD_WIDTH-1:0]     reg1_out,
  output logic [WORD_WIDTH-1:0]     reg2_out,
  output logic [REG_ADDR_WIDTH-1:0] dst_out,
  output logic [REG_ADDR_WIDTH-1:0] src1_out,
  output logic [REG_ADDR_WIDTH-1:0] src2_out,
  output logic [23:0]               imm_out,
  output logic [11:0]               shifter_out,
  output logic [CTRL_WIDTH-1:0]     ctrl_out,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  // Position of mem_write inside {update,B,EX_command[3:0],mem_write,mem_read,WB_en,Imm}
  localparam int c_MEM_WRITE_BIT = 3;

  logic [REG_ADDR_WIDTH-1:0] w_src1;
  logic [REG_ADDR_WIDTH-1:0] w_src2;
  logic                      w_ex_src1;
  logic                      w_ex_src2;
  logic                      w_hazard;

  // Stores read Rd as the second operand (data to store), others read Rm
  assign w_src1 = instruction_in[16 +: REG_ADDR_WIDTH];
  assign w_src2 = ctrl_in[c_MEM_WRITE_BIT] ? instruction_in[12 +: REG_ADDR_WIDTH]
                                           : instruction_in[0 +: REG_ADDR_WIDTH];
  assign src1   = w_src1;
  assign src2   = w_src2;

  assign w_ex_src1 = ex_wb_en && (ex_dst == w_src1);
  assign w_ex_src2 = ex_wb_en && (ex_dst == w_src2);

`ifdef ID_FORWARDING_EN
  // EX/MEM results are forwarded downstream; only a load in EX cannot be
  logic w_unused;
  assign w_unused = ^{instruction_in[WORD_WIDTH-1:24], mem_wb_en, mem_dst};
  assign w_hazard = in_valid && !flush && ex_mem_read &&
                    ((use_src1 && w_ex_src1) || (use_src2 && w_ex_src2));
`else
  logic w_mem_src1;
  logic w_mem_src2;
  logic w_unused;
  assign w_unused   = ^{instruction_in[WORD_WIDTH-1:24], ex_mem_read};
  assign w_mem_src1 = mem_wb_en && (mem_dst == w_src1);
  assign w_mem_src2 = mem_wb_en && (mem_dst == w_src2);
  // No forwarding: wait until neither EX nor MEM still owes a source register
  assign w_hazard   = in_valid && !flush &&
                      ((use_src1 && (w_ex_src1 || w_mem_src1)) ||
                       (use_src2 && (w_ex_src2 || w_mem_src2)));
`endif

  assign hazard_stall = w_hazard;

  // Pipeline register: flush and stall insert a bubble, otherwise capture decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      pc_out      <= '0;
      reg1_out    <= '0;
      reg2_out    <= '0;
      dst_out     <= '0;
      src1_out    <= '0;
      src2_out    <= '0;
      imm_out     <= '0;
      shifter_out <= '0;
      ctrl_out    <= '0;
    end else if (flush || w_hazard) begin
      out_valid <= 1'b0;
      ctrl_out  <= '0;
    end else begin
      out_valid   <= in_valid;
      pc_out      <= pc_in;
      reg1_out    <= reg1_in;
      reg2_out    <= reg2_in;
      dst_out     <= instruction_in[12 +: REG_ADDR_WIDTH];
      src1_out    <= w_src1;
      src2_out    <= w_src2;
      imm_out     <= instruction_in[23:0];
      shifter_out <= instruction_in[11:0];
      ctrl_out    <= in_valid ? ctrl_in : '0;
    end
  end

  // Saturating count of cycles lost to hazards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (w_hazard && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 32, datapath word width.
REQ-002 Parameter REG_ADDR_WIDTH, default 4, register-file address width.
REQ-003 Parameter CTRL_WIDTH, default 10, packed control-bundle width {update,B,EX_command[3:0],mem_write,mem_read,WB_en,Imm}.
REQ-004 Parameter CNT_WIDTH, default 16, stall-counter width.
REQ-005 clk  input  1  single clock, all state rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 pc_in, instruction_in  input  WORD_WIDTH  fetched PC and instruction.
REQ-008 in_valid  input  1  instruction_in holds a real instruction.
REQ-009 ctrl_in  input  CTRL_WIDTH  control-unit decode of instruction_in.
REQ-010 use_src1, use_src2  input  1  instruction reads Rn / second source.
REQ-011 reg1_in, reg2_in  input  WORD_WIDTH  register-file read data for src1/src2.
REQ-012 ex_wb_en, ex_mem_read  input  1  EX-stage writeback enable, EX-stage load.
REQ-013 ex_dst, mem_dst  input  REG_ADDR_WIDTH  EX/MEM destination registers; mem_wb_en input 1.
REQ-014 flush  input  1  branch taken, kill the decode slot.
REQ-015 src1, src2  output  REG_ADDR_WIDTH  combinational register-file read addresses.
REQ-016 hazard_stall  output  1  combinational; freezes PC and IF/ID register.
REQ-017 out_valid  output  1; pc_out, reg1_out, reg2_out  output  WORD_WIDTH; dst_out, src1_out, src2_out  output  REG_ADDR_WIDTH; imm_out  output  24; shifter_out  output  12; ctrl_out  output  CTRL_WIDTH; stall_cnt  output  CNT_WIDTH.

Function
REQ-018 src1 SHALL be instruction_in[19:16]; src2 SHALL be instruction_in[15:12] when ctrl_in mem_write bit is 1, else instruction_in[3:0].
REQ-019 match_ex(x) SHALL be ex_wb_en && ex_dst==x; match_mem(x) SHALL be mem_wb_en && mem_dst==x.
REQ-020 hazard_stall SHALL be 0 whenever flush=1 or in_valid=0.
REQ-021 ID/EX register SHALL update every rising edge with priority flush > hazard_stall > advance.
REQ-022 flush: out_valid<=0, ctrl_out<=0, other fields hold.
REQ-023 hazard_stall: bubble inserted -- out_valid<=0, ctrl_out<=0, other fields hold; instruction stays at input next cycle.
REQ-024 advance: all fields captured from current inputs; out_valid<=in_valid; ctrl_out<=in_valid ? ctrl_in : 0.
REQ-025 Captured fields: dst_out=instruction_in[15:12], imm_out=instruction_in[23:0], shifter_out=instruction_in[11:0], src1_out/src2_out=src1/src2.
REQ-026 Latency: one cycle from an accepted instruction to out_valid=1.
REQ-027 stall_cnt SHALL increment by 1 each cycle hazard_stall=1, saturating at all-ones (no wrap).
REQ-028 ctrl_out SHALL never be non-zero while out_valid=0.

Reset
REQ-029 rst=0 SHALL asynchronously clear every registered output (out_valid, pc_out, reg1_out, reg2_out, dst_out, src1_out, src2_out, imm_out, shifter_out, ctrl_out, stall_cnt) to 0.
REQ-030 Reset asserted mid-stall SHALL drop out_valid immediately; first edge after release advances normally.

Configuration
REQ-031 Macro ID_FORWARDING_EN defined: hazard_stall = in_valid && !flush && ex_mem_read && ((use_src1 && match_ex(src1)) || (use_src2 && match_ex(src2))) -- load-use only, EX/MEM forwarding downstream.
REQ-032 Macro ID_FORWARDING_EN undefined: hazard_stall = in_valid && !flush && ((use_src1 && (match_ex(src1)||match_mem(src1))) || (use_src2 && (match_ex(src2)||match_mem(src2)))).

Verification
REQ-033 Reset: rst=0 during valid traffic -> all outputs 0 same cycle, stall_cnt=0.
REQ-034 Independent instr pc_in=0x10, ctrl_in=0x0AA, in_valid=1, no matches -> next edge out_valid=1, pc_out=0x10, ctrl_out=0x0AA.
REQ-035 Forwarding off: ex_wb_en=1, ex_dst=3, src1=3, use_src1=1 -> hazard_stall=1, out_valid=0, ctrl_out=0, stall_cnt=1; clear ex_wb_en -> instruction advances next edge.
REQ-036 Forwarding on: same as REQ-035 with ex_mem_read=0 -> no stall; ex_mem_read=1 -> one bubble; mem_dst match alone -> no stall.
REQ-037 flush=1 with simultaneous hazard -> hazard_stall=0, out_valid=0 next edge, stall_cnt unchanged.
REQ-038 CNT_WIDTH=4, hold hazard 20 cycles -> stall_cnt saturates at 15.
